// File: rtl/hilo_div_ctrl.sv
// HI/LO register file with a fixed-latency sequencer for an external combinational divider.
// Holds DIV operands for DIV_LAT cycles, then retires remainder->HI and quotient->LO.
module hilo_div_ctrl #(
   parameter int unsigned DIV_LAT = 32
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        mf_req,
   input  logic        mf_sel,
   input  logic [31:0] div_q,
   input  logic [31:0] div_r,
   output logic [31:0] div_a,
   output logic [31:0] div_b,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] rd_data,
   output logic        busy,
   output logic        stall,
   output logic        done,
   output logic        div_zero
);

   typedef enum logic [1:0] {IDLE, RUN, WB} state_t;

   localparam logic [7:0] LAT_M1 = 8'(DIV_LAT - 1);

   state_t      state_reg, state_next;
   logic [7:0]  cnt_reg, cnt_next;
   logic        zero_reg, zero_next;
   logic [31:0] hi_reg, hi_next;
   logic [31:0] lo_reg, lo_next;
   logic [31:0] a_reg, a_next;
   logic [31:0] b_reg, b_next;
   logic        busy_reg, busy_next;
   logic        done_reg, done_next;
   logic        dz_reg, dz_next;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         zero_reg  <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
         a_reg     <= '0;
         b_reg     <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         dz_reg    <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         zero_reg  <= zero_next;
         hi_reg    <= hi_next;
         lo_reg    <= lo_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
         dz_reg    <= dz_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      zero_next  = zero_reg;
      hi_next    = hi_reg;
      lo_next    = lo_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      busy_next  = busy_reg;
      done_next  = 1'b0;
      dz_next    = 1'b0;
      case (state_reg)
         IDLE: begin
            busy_next = 1'b0;
            if (start) begin
               case (op)
                  2'b00: begin
                     a_next     = rs_data;
                     b_next     = rt_data;
                     cnt_next   = LAT_M1;
                     zero_next  = (rt_data == 32'd0);
                     busy_next  = 1'b1;
                     state_next = RUN;
                  end
                  2'b01:   hi_next = rs_data;
                  2'b10:   lo_next = rs_data;
                  default: ;
               endcase
            end
         end
         RUN: begin
            busy_next = 1'b1;
            if (cnt_reg == 8'd0) state_next = WB;
            else                 cnt_next   = cnt_reg - 8'd1;
         end
         WB: begin
            // A zero divisor leaves HI/LO intact; the divider output is meaningless then.
            if (!zero_reg) begin
               hi_next = div_r;
               lo_next = div_q;
            end else begin
               dz_next = 1'b1;
            end
            done_next  = 1'b1;
            busy_next  = 1'b0;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   assign div_a    = a_reg;
   assign div_b    = b_reg;
   assign hi       = hi_reg;
   assign lo       = lo_reg;
   assign busy     = busy_reg;
   assign done     = done_reg;
   assign div_zero = dz_reg;
   assign rd_data  = mf_sel ? hi_reg : lo_reg;
   assign stall    = busy_reg & (mf_req | start);

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Randomized self-checking bench for hilo_div_ctrl against a transaction-level HI/LO model.
module tb_hilo_div_ctrl;
   localparam int L = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [1:0]  op = 2'b11;
   logic [31:0] rs_data = '0;
   logic [31:0] rt_data = '0;
   logic        mf_req = 1'b0;
   logic        mf_sel = 1'b0;
   logic [31:0] div_q, div_r, div_a, div_b, hi, lo, rd_data;
   logic        busy, stall, done, div_zero;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_hi = '0;
   logic [31:0] exp_lo = '0;

   hilo_div_ctrl #(.DIV_LAT(L)) dut (
      .clock(clock), .reset(reset), .start(start), .op(op),
      .rs_data(rs_data), .rt_data(rt_data), .mf_req(mf_req), .mf_sel(mf_sel),
      .div_q(div_q), .div_r(div_r), .div_a(div_a), .div_b(div_b),
      .hi(hi), .lo(lo), .rd_data(rd_data), .busy(busy), .stall(stall),
      .done(done), .div_zero(div_zero)
   );

   always #5 clock = ~clock;

   // Behavioural stand-in for the downstream combinational signed divider.
   always_comb begin
      if (div_b == 32'd0) begin
         div_q = 32'hdead_beef;
         div_r = 32'h0bad_f00d;
      end else begin
         div_q = 32'($signed(div_a) / $signed(div_b));
         div_r = 32'($signed(div_a) % $signed(div_b));
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, want);
      end
   endtask

   task automatic rand_mf();
      mf_req = 1'($urandom_range(0, 1));
      mf_sel = 1'($urandom_range(0, 1));
   endtask

   // Advance one clock and compare every output against the model.
   task automatic sample(input logic eb, input logic ed, input logic ez);
      @(negedge clock);
      check("busy", 32'(busy), 32'(eb));
      check("done", 32'(done), 32'(ed));
      check("div_zero", 32'(div_zero), 32'(ez));
      check("hi", hi, exp_hi);
      check("lo", lo, exp_lo);
      check("rd_data", rd_data, mf_sel ? exp_hi : exp_lo);
      check("stall", 32'(stall), 32'(eb & (mf_req | start)));
   endtask

   task automatic do_mt(input logic to_hi, input logic [31:0] d);
      start = 1'b1; op = to_hi ? 2'b01 : 2'b10; rs_data = d; rand_mf();
      if (to_hi) exp_hi = d; else exp_lo = d;
      sample(1'b0, 1'b0, 1'b0);
      start = 1'b0;
      $display("MT%s %h -> hi=%h lo=%h", to_hi ? "HI" : "LO", d, hi, lo);
   endtask

   // mode 0: random mf and ignored random starts while busy; mode 1: MFHI held and MTLO pushed each busy cycle.
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input int mode);
      longint sa, sb;
      start = 1'b1; op = 2'b00; rs_data = a; rt_data = b;
      if (mode == 1) begin mf_req = 1'b1; mf_sel = 1'b1; end else rand_mf();
      sample(1'b1, 1'b0, 1'b0);
      check("div_a", div_a, a);
      check("div_b", div_b, b);
      for (int k = 1; k <= L + 1; k++) begin
         if (mode == 1) begin
            start = 1'b1; op = 2'b10; rs_data = $urandom;
         end else begin
            rand_mf();
            start = 1'($urandom_range(0, 1)); op = 2'($urandom); rs_data = $urandom; rt_data = $urandom;
         end
         if (k == L + 1) begin
            sa = longint'($signed(a)); sb = longint'($signed(b));
            if (b != 32'd0) begin
               exp_lo = 32'(sa / sb);
               exp_hi = 32'(sa - (sa / sb) * sb);
            end
            sample(1'b0, 1'b1, b == 32'd0);
         end else begin
            sample(1'b1, 1'b0, 1'b0);
            check("div_a_hold", div_a, a);
            check("div_b_hold", div_b, b);
         end
      end
      start = 1'b0; mf_req = 1'b0;
      $display("DIV %h / %h -> hi=%h lo=%h done=%0b dz=%0b", a, b, hi, lo, done, div_zero);
   endtask

   initial begin
      logic [31:0] a, b;
      int kind;
      // Reset state
      reset = 1'b0;
      sample(1'b0, 1'b0, 1'b0);
      sample(1'b0, 1'b0, 1'b0);
      check("rst_div_a", div_a, 32'd0);
      check("rst_div_b", div_b, 32'd0);
      reset = 1'b1;

      do_div(32'd7, 32'd2, 0);
      check("t1_hi", hi, 32'd1);
      check("t1_lo", lo, 32'd3);
      do_div(32'hFFFF_FFF9, 32'd2, 0);
      check("t2_hi", hi, 32'hFFFF_FFFF);
      check("t2_lo", lo, 32'hFFFF_FFFD);

      do_mt(1'b1, 32'h1234_5678);
      do_mt(1'b0, 32'h9ABC_DEF0);
      do_div(32'd99, 32'd0, 0);
      check("t3_hi", hi, 32'h1234_5678);
      check("t3_lo", lo, 32'h9ABC_DEF0);

      do_div(32'd100, 32'hFFFF_FFFD, 1);
      check("t4_lo_kept", lo, 32'hFFFF_FFDF);
      do_mt(1'b0, 32'hCAFE_0001);
      check("t5_lo", lo, 32'hCAFE_0001);

      // Reset for one edge during RUN cycle 2
      start = 1'b1; op = 2'b00; rs_data = 32'd50; rt_data = 32'd7;
      sample(1'b1, 1'b0, 1'b0);
      start = 1'b0;
      sample(1'b1, 1'b0, 1'b0);
      reset = 1'b0; exp_hi = '0; exp_lo = '0;
      sample(1'b0, 1'b0, 1'b0);
      reset = 1'b1;
      for (int k = 0; k < L + 3; k++) sample(1'b0, 1'b0, 1'b0);
      check("t6_div_a", div_a, 32'd0);
      $display("RESET mid-RUN -> hi=%h lo=%h busy=%0b", hi, lo, busy);

      for (int n = 0; n < 60; n++) begin
         kind = int'($urandom_range(0, 5));
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
         case (kind)
            0, 1, 2: do_div(a, b, 0);
            3: do_mt(1'b1, a);
            4: do_mt(1'b0, a);
            default: begin
               start = 1'($urandom_range(0, 1)); op = 2'b11; rs_data = a; rand_mf();
               sample(1'b0, 1'b0, 1'b0);
               start = 1'b0;
               $display("NOP -> hi=%h lo=%h", hi, lo);
            end
         endcase
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
